score_bcd_counter: RTL

Game score counter that sits directly upstream of the per-digit seven-segment decoders. It counts pipes cleared during a run as packed BCD, tracks the best score across runs, and presents one 4-bit code per display digit. Leading zeros can be replaced by the blank code 4'b1111, which the decoder renders as all segments off.

---
 rtl/score_bcd_counter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - packed-BCD game score counter with best-score tracking
// Optional leading-zero blanking of disp_bcd: define SCORE_BLANK_LZ_EN.
module score_bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pass_in,
  input  logic                  game_over,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   best_bcd,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  new_best,
  output logic                  sat,
  output logic                  running
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   best_q, best_d;
  logic           new_best_q, new_best_d;
  logic           sat_q, sat_d;
  logic           running_q, running_d;
  logic           pass_q;

  logic [W-1:0]   score_inc;
  logic [W-1:0]   score_run;
  logic           inc_carry;
  logic           rise;

  // True when every digit holds 9, i.e. the score cannot advance further.
  function automatic logic is_max(input logic [W-1:0] v);
    logic m;
    m = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) m = 1'b0;
    end
    return m;
  endfunction

  assign rise = pass_in & ~pass_q;

  // Score plus one with BCD ripple carry; a digit at 9 wraps and carries up.
  always_comb begin
    score_inc = score_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // Score after this cycle's pass edge, held once all nines is reached.
  assign score_run = (rise && !is_max(score_q)) ? score_inc : score_q;

  // Next-state logic; start has priority over game_over in every state.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          score_d    = '0;
          sat_d      = 1'b0;
          new_best_d = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          score_d    = '0;
          sat_d      = 1'b0;
          new_best_d = 1'b0;
        end else begin
          score_d = score_run;
          sat_d   = sat_q | is_max(score_run);
          if (game_over) begin
            state_d = OVER;
            // Compare against the score as it will be registered on this edge,
            // so a pass edge coinciding with game_over is included.
            if (score_run > best_q) begin
              best_d     = score_run;
              new_best_d = 1'b1;
            end else begin
              new_best_d = 1'b0;
            end
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d    = RUN;
          score_d    = '0;
          sat_d      = 1'b0;
          new_best_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // All state, including the pass_in edge detector, with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      score_q    <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
      sat_q      <= 1'b0;
      running_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      sat_q      <= sat_d;
      running_q  <= running_d;
      pass_q     <= pass_in;
    end
  end

`ifdef SCORE_BLANK_LZ_EN
  // Blank every digit above the most significant nonzero one; units always shown.
  always_comb begin
    logic lead;
    lead     = 1'b1;
    disp_bcd = score_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (score_q[4*i +: 4] == 4'd0)) begin
        disp_bcd[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign disp_bcd = score_q;
`endif

  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign new_best  = new_best_q;
  assign sat       = sat_q;
  assign running   = running_q;

endmodule
